// File: rtl/uram_event_buffer_tracker.sv
// Buffer bookkeeping for the multi-buffer URAM event store.
// Hands the writer a free buffer on each accepted trigger, tracks how many buffers are
// filled, presents the oldest filled buffer (index + captured header) to the readout SM
// and frees it on the readout-complete flag. Rejected triggers are counted (saturating).
module uram_event_buffer_tracker #(
    parameter int unsigned NBUF_BITS = 2,
    parameter int unsigned HDR_BITS  = 48,
    parameter int unsigned DROP_BITS = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 trig_i,
    input  logic [HDR_BITS-1:0]  hdr_i,
    output logic                 trig_ack_o,
    output logic [NBUF_BITS-1:0] wr_buf_o,
    input  logic                 wr_done_i,
    output logic                 writing_o,
    input  logic                 fw_loading_i,
    output logic                 data_available_o,
    output logic [NBUF_BITS-1:0] rd_buf_o,
    output logic [HDR_BITS-1:0]  header_o,
    input  logic                 complete_i,
    output logic [NBUF_BITS:0]   count_o,
    output logic                 full_o,
    output logic [DROP_BITS-1:0] drop_count_o,
    output logic                 err_o
);

    localparam int unsigned NBUF = 1 << NBUF_BITS;
    localparam int unsigned CntW = NBUF_BITS + 1;
    localparam logic [CntW-1:0] CntFull = CntW'(NBUF);

    // State registers
    logic [NBUF_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [NBUF_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 writing_q, writing_d;
    logic                 trig_ack_q, trig_ack_d;
    logic                 data_avail_q, data_avail_d;
    logic                 full_q, full_d;
    logic [DROP_BITS-1:0] drop_q, drop_d;
    logic                 err_q, err_d;
    logic [HDR_BITS-1:0]  hdr_q [NBUF];
    logic [HDR_BITS-1:0]  hdr_d [NBUF];

    // Decoded events for this cycle
    logic accept;
    logic wr_valid;
    logic cpl_valid;

    // Qualify the incoming requests against the current bookkeeping state.
    always_comb begin
        accept    = trig_i && !writing_q && (count_q < CntFull) && !fw_loading_i;
        wr_valid  = wr_done_i && writing_q;
        cpl_valid = complete_i && (count_q != '0);
    end

    // Next-state for pointers, fill count, write-in-flight and status flags.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        writing_d    = writing_q;
        trig_ack_d   = 1'b0;
        drop_d       = drop_q;
        err_d        = err_q;

        // accept and wr_valid are mutually exclusive: one needs writing low, the other high.
        if (accept) begin
            writing_d  = 1'b1;
            trig_ack_d = 1'b1;
        end else if (trig_i && (drop_q != '1)) begin
            drop_d = drop_q + DROP_BITS'(1);
        end

        if (wr_valid) begin
            writing_d = 1'b0;
            wr_ptr_d  = wr_ptr_q + NBUF_BITS'(1);
        end

        if (cpl_valid) begin
            rd_ptr_d = rd_ptr_q + NBUF_BITS'(1);
        end

        // Simultaneous fill and free leaves the count untouched.
        unique case ({wr_valid, cpl_valid})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        if ((wr_done_i && !writing_q) || (complete_i && (count_q == '0))) begin
            err_d = 1'b1;
        end

        // Registered status flags derive from the next count so they track count_o exactly.
        full_d       = (count_d == CntFull);
        data_avail_d = (count_d != '0) && !fw_loading_i;
    end

    // Header capture: only the buffer being handed to the writer is updated.
    always_comb begin
        for (int i = 0; i < int'(NBUF); i++) begin
            hdr_d[i] = hdr_q[i];
        end
        if (accept) begin
            hdr_d[wr_ptr_q] = hdr_i;
        end
    end

    // Bookkeeping state register; reset discards any write in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            writing_q    <= 1'b0;
            trig_ack_q   <= 1'b0;
            data_avail_q <= 1'b0;
            full_q       <= 1'b0;
            drop_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            writing_q    <= writing_d;
            trig_ack_q   <= trig_ack_d;
            data_avail_q <= data_avail_d;
            full_q       <= full_d;
            drop_q       <= drop_d;
            err_q        <= err_d;
        end
    end

    // Per-buffer header store.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NBUF); i++) begin
                hdr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NBUF); i++) begin
                hdr_q[i] <= hdr_d[i];
            end
        end
    end

    // Output drive; header_o is a plain mux of stored headers by the read pointer.
    always_comb begin
        trig_ack_o       = trig_ack_q;
        wr_buf_o         = wr_ptr_q;
        writing_o        = writing_q;
        data_available_o = data_avail_q;
        rd_buf_o         = rd_ptr_q;
        header_o         = hdr_q[rd_ptr_q];
        count_o          = count_q;
        full_o           = full_q;
        drop_count_o     = drop_q;
        err_o            = err_q;
    end

endmodule

// File: tb/tb_uram_event_buffer_tracker.sv
// Self-checking bench for uram_event_buffer_tracker: a small reference model tracks
// pointers/count/drops/errors, and a header scoreboard queue is pushed on each accepted
// trigger and popped when the readout completes that buffer.
module tb_uram_event_buffer_tracker;

    localparam int unsigned NBUF_BITS = 2;
    localparam int unsigned HDR_BITS  = 48;
    localparam int unsigned DROP_BITS = 16;
    localparam int          NBUF      = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 trig_i;
    logic [HDR_BITS-1:0]  hdr_i;
    logic                 trig_ack_o;
    logic [NBUF_BITS-1:0] wr_buf_o;
    logic                 wr_done_i;
    logic                 writing_o;
    logic                 fw_loading_i;
    logic                 data_available_o;
    logic [NBUF_BITS-1:0] rd_buf_o;
    logic [HDR_BITS-1:0]  header_o;
    logic                 complete_i;
    logic [NBUF_BITS:0]   count_o;
    logic                 full_o;
    logic [DROP_BITS-1:0] drop_count_o;
    logic                 err_o;

    uram_event_buffer_tracker #(
        .NBUF_BITS (NBUF_BITS),
        .HDR_BITS  (HDR_BITS),
        .DROP_BITS (DROP_BITS)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .trig_i           (trig_i),
        .hdr_i            (hdr_i),
        .trig_ack_o       (trig_ack_o),
        .wr_buf_o         (wr_buf_o),
        .wr_done_i        (wr_done_i),
        .writing_o        (writing_o),
        .fw_loading_i     (fw_loading_i),
        .data_available_o (data_available_o),
        .rd_buf_o         (rd_buf_o),
        .header_o         (header_o),
        .complete_i       (complete_i),
        .count_o          (count_o),
        .full_o           (full_o),
        .drop_count_o     (drop_count_o),
        .err_o            (err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    int          m_wr, m_rd, m_cnt, m_drop;
    bit          m_writing, m_err, m_ack, m_fw;
    logic [47:0] hdr_q [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_cnt = 0; m_drop = 0;
        m_writing = 0; m_err = 0; m_ack = 0;
        hdr_q.delete();
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"}, 64'(count_o), 64'(m_cnt));
        check_eq({tag, ".full"}, 64'(full_o), 64'(m_cnt == NBUF));
        check_eq({tag, ".rd_buf"}, 64'(rd_buf_o), 64'(m_rd));
        check_eq({tag, ".wr_buf"}, 64'(wr_buf_o), 64'(m_wr));
        check_eq({tag, ".writing"}, 64'(writing_o), 64'(m_writing));
        check_eq({tag, ".trig_ack"}, 64'(trig_ack_o), 64'(m_ack));
        check_eq({tag, ".data_avail"}, 64'(data_available_o), 64'((m_cnt != 0) && !m_fw));
        check_eq({tag, ".drop"}, 64'(drop_count_o), 64'(m_drop));
        check_eq({tag, ".err"}, 64'(err_o), 64'(m_err));
        if (m_cnt > 0) check_eq({tag, ".header"}, 64'(header_o), 64'(hdr_q[0]));
    endtask

    task automatic do_reset(input string tag);
        rst_i = 1'b1;
        trig_i = 1'b0; wr_done_i = 1'b0; complete_i = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        check_eq({tag, ".header0"}, 64'(header_o), 64'h0);
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
        m_ack = 0;
    endtask

    task automatic do_trig(input logic [47:0] h, input string tag);
        bit acc;
        acc = !m_writing && (m_cnt < NBUF) && !m_fw;
        trig_i = 1'b1; hdr_i = h;
        step();
        trig_i = 1'b0;
        m_ack = acc;
        if (acc) begin
            m_writing = 1;
            hdr_q.push_back(h);
        end else if (m_drop < 65535) begin
            m_drop++;
        end
        check_all(tag);
    endtask

    task automatic do_done(input string tag);
        wr_done_i = 1'b1;
        step();
        wr_done_i = 1'b0;
        m_ack = 0;
        if (m_writing) begin
            m_writing = 0; m_wr = (m_wr + 1) % NBUF; m_cnt++;
        end else begin
            m_err = 1;
        end
        check_all(tag);
    endtask

    task automatic do_complete(input string tag);
        if (m_cnt > 0) begin
            check_eq({tag, ".pre_header"}, 64'(header_o), 64'(hdr_q[0]));
            check_eq({tag, ".pre_rd_buf"}, 64'(rd_buf_o), 64'(m_rd));
        end
        complete_i = 1'b1;
        step();
        complete_i = 1'b0;
        m_ack = 0;
        if (m_cnt > 0) begin
            void'(hdr_q.pop_front());
            m_rd = (m_rd + 1) % NBUF; m_cnt--;
        end else begin
            m_err = 1;
        end
        check_all(tag);
    endtask

    task automatic do_both(input string tag);
        bit wv, cv;
        wv = m_writing;
        cv = (m_cnt > 0);
        wr_done_i = 1'b1; complete_i = 1'b1;
        step();
        wr_done_i = 1'b0; complete_i = 1'b0;
        m_ack = 0;
        if (cv) begin
            void'(hdr_q.pop_front());
            m_rd = (m_rd + 1) % NBUF;
        end
        if (wv) begin
            m_writing = 0; m_wr = (m_wr + 1) % NBUF;
        end
        m_cnt = m_cnt + int'(wv) - int'(cv);
        if (!wv || !cv) m_err = 1;
        check_all(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        trig_i = 1'b0; hdr_i = '0; wr_done_i = 1'b0; complete_i = 1'b0;
        fw_loading_i = 1'b0; m_fw = 0; rst_i = 1'b1;
        model_reset();

        // Reset state and a single event round trip
        do_reset("reset");
        do_trig(48'h0000_1234_5678, "single.trig");
        idle(9);
        check_all("single.wait");
        do_done("single.done");
        do_complete("single.cpl");

        // Fill to full, overflow trigger, drain with header order and rd wrap
        do_reset("fill.reset");
        for (int i = 1; i <= 4; i++) begin
            do_trig(48'(i), "fill.trig");
            idle(2);
            do_done("fill.done");
        end
        do_trig(48'h5, "fill.overflow");
        idle(1);
        check_all("fill.ack_low");
        for (int i = 0; i < 4; i++) do_complete("drain.cpl");

        // Simultaneous wr_done and complete at count 2
        do_reset("sim.reset");
        for (int i = 0; i < 2; i++) begin
            do_trig(48'hA0 + 48'(i), "sim.trig");
            do_done("sim.done");
        end
        do_trig(48'hA2, "sim.trig3");
        do_both("sim.both");

        // Trigger while writing is dropped; wr_buf stays put
        do_reset("tww.reset");
        do_trig(48'hBEEF, "tww.trig");
        idle(2);
        do_trig(48'hDEAD, "tww.trig2");
        do_done("tww.done");

        // Firmware load masks data_available and drops triggers
        fw_loading_i = 1'b1; m_fw = 1;
        idle(1);
        check_all("fw.masked");
        do_trig(48'hF00D, "fw.trig");
        fw_loading_i = 1'b0; m_fw = 0;
        idle(1);
        check_all("fw.release");

        // Protocol errors
        do_reset("err.reset1");
        do_complete("err.cpl_empty");
        do_reset("err.reset2");
        do_done("err.done_idle");
        do_both("err.both_empty");

        // Asynchronous reset in the middle of a write
        do_reset("mid.reset");
        do_trig(48'h7777, "mid.trig");
        #3;
        rst_i = 1'b1;
        #1;
        model_reset();
        check_all("mid.async");
        step();
        rst_i = 1'b0;
        step();
        check_all("mid.after");

        // Drop counter saturation while a write is held in flight
        do_trig(48'h1111, "sat.trig");
        trig_i = 1'b1;
        repeat (65540) step();
        trig_i = 1'b0;
        m_drop = 65535; m_ack = 0;
        check_all("sat.drop");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uram_event_buffer_tracker.md
Name: uram_event_buffer_tracker

Overview:
- Upstream neighbour of the URAM event readout state machine; owns buffer bookkeeping for the multi-buffer URAM event store.
- Accepts triggers and hands the writer a free buffer index; counts filled buffers; drives data_available to the readout SM and frees buffers on its complete flag.
- Captures a per-event header word at trigger acceptance and presents the header of the oldest filled buffer to the readout path.
- Counts triggers dropped for lack of a free buffer.

Parameters:
- NBUF_BITS, 2, log2 of buffer count (NBUF = 2**NBUF_BITS = 4).
- HDR_BITS, 48, width of the captured event header (event number + timestamp).
- DROP_BITS, 16, width of the saturating dropped-trigger counter.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  asynchronous, active-high reset.
- trig_i  in  1  trigger request, single-cycle pulse.
- hdr_i  in  HDR_BITS  header value, sampled on the cycle trig_i is accepted.
- trig_ack_o  out  1  one-cycle pulse: trigger accepted, write begins into wr_buf_o.
- wr_buf_o  out  NBUF_BITS  buffer index the writer must fill.
- wr_done_i  in  1  pulse: writer finished filling wr_buf_o.
- writing_o  out  1  a write is in flight (between acceptance and wr_done_i).
- fw_loading_i  in  1  firmware-load mode: blocks triggers and masks data_available_o.
- data_available_o  out  1  at least one filled buffer is awaiting readout.
- rd_buf_o  out  NBUF_BITS  oldest filled buffer index (readout source).
- header_o  out  HDR_BITS  header stored for rd_buf_o.
- complete_i  in  1  readout-complete flag from the readout SM (already clock-enable qualified, single cycle).
- count_o  out  NBUF_BITS+1  number of filled buffers, 0..NBUF.
- full_o  out  1  count_o == NBUF.
- drop_count_o  out  DROP_BITS  triggers rejected since reset; saturates.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (asynchronous, rst_i high): wr_ptr=0, rd_ptr=0, count=0, writing=0, drop_count=0, err=0, header store=0.
- Reset value of every output: trig_ack_o=0, wr_buf_o=0, writing_o=0, data_available_o=0, rd_buf_o=0, header_o=0, count_o=0, full_o=0, drop_count_o=0, err_o=0.
- A write in flight when reset asserts is discarded.
- Trigger acceptance condition: trig_i && !writing && count < NBUF && !fw_loading_i.
- On acceptance:
  - next cycle: trig_ack_o=1 for exactly one cycle and writing_o=1;
  - hdr_i is latched into hdr_store[wr_ptr];
  - wr_buf_o holds wr_ptr until wr_done_i.
- A trig_i that is not accepted increments drop_count_o by 1; the counter saturates at all-ones and never wraps.
- wr_done_i while writing=1:
  - next cycle: writing=0, wr_ptr=wr_ptr+1 (mod NBUF), count+1.
  - A trigger on that same cycle is rejected (writing is still 1) and counted as dropped.
- wr_done_i while writing=0: ignored; err_o=1.
- complete_i while count>0: next cycle: rd_ptr=rd_ptr+1 (mod NBUF), count-1.
- complete_i while count==0: ignored; err_o=1.
- wr_done_i and complete_i on the same cycle, both valid: both pointers advance and count is unchanged.
  - Valid at full: count stays NBUF and full_o stays high.
  - With count==0: wr_done_i increments count; complete_i is an error.
- Output timing:
  - count_o, full_o and rd_buf_o are registered.
  - data_available_o = (count != 0) && !fw_loading_i, registered; it rises one cycle after a counted wr_done_i.
  - Decrement to 0 clears data_available_o one cycle after complete_i. This lands before the readout SM's next HEADER0 evaluation, which is at least two clock enables later.
- header_o = hdr_store[rd_ptr], a combinational mux of registers; valid whenever data_available_o=1.
- hdr_store[wr_ptr] is never overwritten while that buffer is filled. Acceptance is blocked at full, so wr_ptr never equals a filled rd_ptr.
- fw_loading_i:
  - rejects triggers, which are counted as dropped;
  - forces data_available_o=0;
  - pointers, count and any in-flight write are unaffected.
  - On deassertion, data_available_o reflects count on the next cycle.
- Pointer wrap: plain NBUF_BITS modular increment, with no extra wrap bit (count disambiguates full/empty).
- err_o clears only on rst_i.

Test Plan:
- Single event: trig_i with hdr_i=0x0000_1234_5678 → trig_ack_o next cycle, wr_buf_o=0. wr_done_i 10 cycles later → data_available_o=1, rd_buf_o=0, header_o=0x0000_1234_5678. complete_i → count_o=0, data_available_o=0, rd_buf_o=1.
- Fill to full: 4 trigger/wr_done pairs with headers 1..4 → full_o=1, count_o=4. A 5th trig_i → no trig_ack_o, drop_count_o=1. Four complete_i pulses → header_o steps 1,2,3,4 and rd_buf_o wraps 0→1→2→3→0.
- Simultaneous events at count=2: wr_done_i and complete_i on the same cycle → count_o stays 2, wr_buf_o and rd_buf_o both advance by 1.
- Trigger while writing: second trig_i 3 cycles after acceptance → drop_count_o=1, wr_buf_o unchanged. Saturation: force 65536 dropped triggers → drop_count_o=0xFFFF.
- fw_loading_i=1 with count=1 → data_available_o=0 next cycle, trig_i dropped. fw_loading_i=0 → data_available_o=1 next cycle.
- Protocol errors and mid-operation reset:
  - complete_i at count=0 → err_o=1, count_o=0;
  - wr_done_i with writing_o=0 → err_o=1;
  - rst_i mid-write → all outputs 0 immediately, asynchronously.
